// File: rtl/nor_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise-NOR unit among N_REQ requesters.
// One operation in flight: IDLE (grant + operand latch) -> EVAL (compute) -> DONE (respond).
module nor_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_y,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [W-1:0]       opa_q, opa_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [W-1:0]       rsp_y_q, rsp_y_d;
  logic [15:0]        op_count_q, op_count_d;

  logic [W-1:0]       a_slice [N_REQ];
  logic [W-1:0]       b_slice [N_REQ];
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  int                 pick_cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_slice[gi] = op_a[gi*W +: W];
      assign b_slice[gi] = op_b[gi*W +: W];
    end
  endgenerate

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      pick_cand = (int'(last_q) + off) % N_REQ;
      if (!pick_found && req[pick_cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(pick_cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rsp_y_d    = rsp_y_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          opa_d   = a_slice[pick_idx];
          opb_d   = b_slice[pick_idx];
          gnt_d   = N_REQ'(1) << pick_idx;
          last_d  = pick_idx;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Only the latched operands reach the NOR cells.
        rsp_y_d = ~(opa_q | opb_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        op_count_d = op_count_q + 16'd1;
        gnt_d      = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_q     <= IW'(N_REQ - 1);
      opa_q      <= '0;
      opb_q      <= '0;
      rsp_y_q    <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rsp_y_q    <= rsp_y_d;
      op_count_q <= op_count_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = (state_q == ST_DONE) ? gnt_q : '0;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_nor_arbiter.sv
// Scoreboard bench for nor_arbiter: expected responses queued at stimulus time,
// popped by a monitor on each rsp_valid pulse; per-scenario tasks check timing inline.
module tb_nor_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*W-1:0] op_a = '0;
  logic [N_REQ*W-1:0] op_b = '0;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_y;
  logic               busy;
  logic [15:0]        op_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nor_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_REQ-1:0] oh(input int i);
    return N_REQ'(1) << i;
  endfunction

  task automatic push_exp(input int idx);
    exp_t e;
    e.idx = idx;
    e.y   = ~(op_a[idx*W +: W] | op_b[idx*W +: W]);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rsp_y=%h, none expected", rsp_valid, rsp_y);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== oh(mon_e.idx)) begin
          errors++;
          $display("FAIL rsp_valid: got %b expected %b", rsp_valid, oh(mon_e.idx));
        end
        checks++;
        if (rsp_y !== mon_e.y) begin
          errors++;
          $display("FAIL rsp_y: requester %0d got %h expected %h", mon_e.idx, rsp_y, mon_e.y);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_y, busy, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rsp_valid=%b rsp_y=%h busy=%b op_count=%0d expected all 0",
               gnt, rsp_valid, rsp_y, busy, op_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_y, busy, op_count} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: gnt=%b rsp_valid=%b rsp_y=%h busy=%b op_count=%0d expected all 0",
               gnt, rsp_valid, rsp_y, busy, op_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    op_a[1*W +: W] = 8'h0F;
    op_b[1*W +: W] = 8'h30;
    req = 4'b0010;
    push_exp(1);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b busy=%b expected gnt=0010 busy=1", gnt, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL single_rsp_timing: rsp_valid=%b expected 0010", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || rsp_y !== 8'hC0 || op_count !== 16'd1) begin
      errors++;
      $display("FAIL single_after: gnt=%b busy=%b rsp_y=%h op_count=%0d expected 0000/0/c0/1",
               gnt, busy, rsp_y, op_count);
    end
    $display("test_single done: y=%h count=%0d", rsp_y, op_count);
  endtask

  task automatic test_fairness();
    int n;
    int grant_cyc [5];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i*W +: W] = 8'(8'h21 * (i + 1));
      op_b[i*W +: W] = 8'(8'h80 >> i);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(k % N_REQ);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt === '0 && n < 8) begin
        @(negedge clk);
        n++;
      end
      grant_cyc[k] = cyc;
      checks++;
      if (gnt !== oh(k % N_REQ)) begin
        errors++;
        $display("FAIL fair_grant: op %0d gnt=%b expected %b", k, gnt, oh(k % N_REQ));
      end
      if (k == 4) req = '0;
      n = 0;
      while (gnt !== '0 && n < 8) begin
        @(negedge clk);
        n++;
      end
      $display("fairness op %0d granted at cycle %0d", k, grant_cyc[k]);
    end
    checks++;
    if (grant_cyc[4] - grant_cyc[0] !== 12) begin
      errors++;
      $display("FAIL fair_throughput: 4 grant gaps took %0d cycles expected 12",
               grant_cyc[4] - grant_cyc[0]);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fair_rsp_pending: %0d responses missing expected 0", sb.size());
    end
  endtask

  task automatic test_operand_hold();
    op_a[2*W +: W] = 8'h12;
    op_b[2*W +: W] = 8'h01;
    req = 4'b0100;
    push_exp(2);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL hold_grant: gnt=%b expected 0100", gnt);
    end
    op_a[2*W +: W] = 8'hFF;
    op_b[2*W +: W] = 8'hFF;
    req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_y !== 8'hEC) begin
      errors++;
      $display("FAIL hold_result: rsp_y=%h expected ec", rsp_y);
    end
    $display("test_operand_hold done: y=%h", rsp_y);
  endtask

  task automatic test_reset_mid();
    op_a[0*W +: W] = 8'h55;
    op_b[0*W +: W] = 8'h0A;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: gnt=%b busy=%b expected 0001/1", gnt, busy);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_y, busy, op_count} !== '0) begin
      errors++;
      $display("FAIL midrst_abort: gnt=%b rsp_valid=%b rsp_y=%h busy=%b op_count=%0d expected all 0",
               gnt, rsp_valid, rsp_y, busy, op_count);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL midrst_no_pulse: rsp_valid=%b expected 0000", rsp_valid);
    end
    rst = 1'b0;
    req = 4'b0011;
    push_exp(0);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_priority: gnt=%b expected 0001", gnt);
    end
    req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("FAIL midrst_count: op_count=%0d expected 1", op_count);
    end
    $display("test_reset_mid done: count=%0d", op_count);
  endtask

  task automatic test_counter_wrap();
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: op_count=%h expected ffff", op_count);
    end
    op_a[3*W +: W] = 8'hA0;
    op_b[3*W +: W] = 8'h05;
    req = 4'b1000;
    push_exp(3);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (op_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count: op_count=%h expected 0000", op_count);
    end
    $display("test_counter_wrap done: count=%h", op_count);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_operand_hold();
    test_reset_mid();
    test_counter_wrap();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses never arrived", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
